// File: rtl/time_clock_pkg.sv
// Shared types and constants for the time-set controller.
package time_clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_e;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;

  // Digit order {hour10, hour1, min10, min1}; 1 = blank.
  localparam logic [3:0] BLANK_NONE = 4'b0000;
  localparam logic [3:0] BLANK_HOUR = 4'b1100;
  localparam logic [3:0] BLANK_MIN  = 4'b0011;

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Registered rising-edge detector for one debounced, clock-synchronous button level.
module btn_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  logic prev_q, prev_d;

  always_comb prev_d = i_btn;

  always_ff @(posedge i_clk) begin
    if (i_reset) prev_q <= 1'b0;
    else         prev_q <= prev_d;
  end

  assign o_press = i_btn & ~prev_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time register owner: runs hh:mm:ss.cc on i_tick, or edits hour/min with blink.
// Optional build macro TIME_SET_AUTOREPEAT_EN adds hold-to-repeat stepping.
module time_set_ctrl
  import time_clock_pkg::*;
#(
  parameter int TICK_PER_SEC = 100,
  parameter int BLINK_TICKS  = 50,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic [6:0] o_hour,
  output logic [6:0] o_min,
  output logic [6:0] o_sec,
  output logic [6:0] o_msec,
  output logic [1:0] o_state,
  output logic       o_force_hm,
  output logic [3:0] o_blank
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [6:0]    MSEC_MAX   = 7'(TICK_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] max,
                                           input logic inc);
    if (inc) return (v == max)  ? 7'd0 : v + 7'd1;
    else     return (v == 7'd0) ? max  : v - 7'd1;
  endfunction

  logic mode_p, up_p, dn_p;

  btn_edge u_edge_mode (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_mode), .o_press(mode_p));
  btn_edge u_edge_up   (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_up),   .o_press(up_p));
  btn_edge u_edge_dn   (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_down), .o_press(dn_p));

  state_e        state_q, state_d;
  logic [6:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d, msec_q, msec_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic          force_q, force_d;
  logic [3:0]    blank_q, blank_d;

  logic rpt_up, rpt_dn;

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rpt_fire;

  // After the first repeat the counter reloads so the next fire lands REPEAT_RATE ticks later.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    rpt_fire   = 1'b0;
    if (state_q == ST_RUN || mode_p || !(i_btn_up ^ i_btn_down)) begin
      hold_cnt_d = '0;
    end else if (i_tick) begin
      if (hold_cnt_q == HW'(REPEAT_DELAY - 1)) begin
        rpt_fire   = 1'b1;
        hold_cnt_d = HW'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) hold_cnt_q <= '0;
    else         hold_cnt_q <= hold_cnt_d;
  end

  assign rpt_up = rpt_fire & i_btn_up;
  assign rpt_dn = rpt_fire & i_btn_down;
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  logic step_up, step_dn;
  assign step_up = (up_p & ~dn_p) | rpt_up;
  assign step_dn = (dn_p & ~up_p) | rpt_dn;

  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    msec_d      = msec_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          state_d     = ST_SET_HOUR;
          blink_cnt_d = '0;
          blink_ph_d  = 1'b0;
        end else if (i_tick) begin
          if (msec_q != MSEC_MAX) msec_d = msec_q + 7'd1;
          else begin
            msec_d = '0;
            if (sec_q != SEC_MAX) sec_d = sec_q + 7'd1;
            else begin
              sec_d = '0;
              if (min_q != MIN_MAX) min_d = min_q + 7'd1;
              else begin
                min_d  = '0;
                hour_d = wrap_step(hour_q, HOUR_MAX, 1'b1);
              end
            end
          end
        end
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        if (mode_p) begin
          blink_cnt_d = '0;
          blink_ph_d  = 1'b0;
          if (state_q == ST_SET_HOUR) state_d = ST_SET_MIN;
          else begin
            state_d = ST_RUN;
            sec_d   = '0;
            msec_d  = '0;
          end
        end else if (step_up || step_dn) begin
          // Edits restart the blink so the new value is shown at once.
          blink_cnt_d = '0;
          blink_ph_d  = 1'b0;
          if (state_q == ST_SET_HOUR) hour_d = wrap_step(hour_q, HOUR_MAX, step_up);
          else                        min_d  = wrap_step(min_q,  MIN_MAX,  step_up);
        end else if (i_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    force_d = (state_d != ST_RUN);
    blank_d = BLANK_NONE;
    if (blink_ph_d && state_d == ST_SET_HOUR) blank_d = BLANK_HOUR;
    if (blink_ph_d && state_d == ST_SET_MIN)  blank_d = BLANK_MIN;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      msec_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      force_q     <= 1'b0;
      blank_q     <= BLANK_NONE;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      msec_q      <= msec_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      force_q     <= force_d;
      blank_q     <= blank_d;
    end
  end

  assign o_hour     = hour_q;
  assign o_min      = min_q;
  assign o_sec      = sec_q;
  assign o_msec     = msec_q;
  assign o_state    = state_q;
  assign o_force_hm = force_q;
  assign o_blank    = blank_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: stimulus queues expected snapshots, a negedge monitor checks them.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, b_mode, b_up, b_dn;
  logic [6:0] hour, min, sec, msec;
  logic [1:0] st;
  logic       force_hm;
  logic [3:0] blank;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick),
    .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_dn),
    .o_hour(hour), .o_min(min), .o_sec(sec), .o_msec(msec),
    .o_state(st), .o_force_hm(force_hm), .o_blank(blank)
  );

  typedef struct packed {
    logic [6:0] h, m, s, ms;
    logic [1:0] st;
    logic       f;
    logic [3:0] b;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    n_vec = 0, n_bad = 0;

  snap_t mon_a, mon_e;
  string mon_n;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = '{h: hour, m: min, s: sec, ms: msec, st: st, f: force_hm, b: blank};
      n_vec++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL %s: got %0d:%0d:%0d.%0d st=%0d f=%0d blank=%b, want %0d:%0d:%0d.%0d st=%0d f=%0d blank=%b",
                 mon_n, mon_a.h, mon_a.m, mon_a.s, mon_a.ms, mon_a.st, mon_a.f, mon_a.b,
                 mon_e.h, mon_e.m, mon_e.s, mon_e.ms, mon_e.st, mon_e.f, mon_e.b);
      end
    end
  end

  task automatic cyc(input logic m, input logic u, input logic d, input logic t);
    b_mode = m; b_up = u; b_dn = d; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    cyc(m, u, d, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input int h, input int m, input int s, input int ms,
                     input int stt, input int f, input logic [3:0] b);
    snap_t e;
    e = '{h: 7'(h), m: 7'(m), s: 7'(s), ms: 7'(ms), st: 2'(stt), f: f[0], b: b};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; b_mode = 1'b0; b_up = 1'b0; b_dn = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("reset", 0, 0, 0, 0, 0, 0, 4'b0000);
    rst = 1'b0;

    press(1, 0, 0);  chk("run_to_set_hour", 0, 0, 0, 0, 1, 1, 4'b0000);
    press(0, 0, 1);  chk("hour_dn_wrap", 23, 0, 0, 0, 1, 1, 4'b0000);
    ticks(10);       chk("set_freezes_time", 23, 0, 0, 0, 1, 1, 4'b0000);
    ticks(39);       chk("blink_phase0_49", 23, 0, 0, 0, 1, 1, 4'b0000);
    ticks(1);        chk("blink_on_50", 23, 0, 0, 0, 1, 1, 4'b1100);
    ticks(50);       chk("blink_off_100", 23, 0, 0, 0, 1, 1, 4'b0000);
    ticks(50);       chk("blink_on_150", 23, 0, 0, 0, 1, 1, 4'b1100);
    press(0, 1, 0);  chk("press_unblanks_up_wrap", 0, 0, 0, 0, 1, 1, 4'b0000);
    press(0, 1, 1);  chk("up_dn_together_ignored", 0, 0, 0, 0, 1, 1, 4'b0000);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("hold_gives_one_step", 1, 0, 0, 0, 1, 1, 4'b0000);
    for (int i = 0; i < 4; i++) press(0, 1, 0);
    press(1, 0, 0);  chk("hour5_to_set_min", 5, 0, 0, 0, 2, 1, 4'b0000);
    for (int i = 0; i < 7; i++) press(0, 1, 0);
    chk("min_up_to_7", 5, 7, 0, 0, 2, 1, 4'b0000);
    rst = 1'b1; cyc(0, 0, 0, 0); rst = 1'b0;
    chk("reset_mid_set_min", 0, 0, 0, 0, 0, 0, 4'b0000);

    press(1, 0, 0); press(0, 0, 1); press(1, 0, 0); press(0, 0, 1);
    chk("min_dn_wrap", 23, 59, 0, 0, 2, 1, 4'b0000);
    press(1, 0, 0);  chk("set_min_to_run", 23, 59, 0, 0, 0, 0, 4'b0000);
    press(0, 1, 0);  chk("up_ignored_in_run", 23, 59, 0, 0, 0, 0, 4'b0000);
    ticks(5999);     chk("preload_23_59_59_99", 23, 59, 59, 99, 0, 0, 4'b0000);
    ticks(1);        chk("full_carry", 0, 0, 0, 0, 0, 0, 4'b0000);
    ticks(150);      chk("run_count_150", 0, 0, 1, 50, 0, 0, 4'b0000);
    press(1, 1, 0);  chk("mode_beats_up", 0, 0, 1, 50, 1, 1, 4'b0000);
    for (int i = 0; i < 4; i++) press(0, 1, 0);
    press(1, 0, 0); press(0, 0, 1);
    chk("min59_hour4", 4, 59, 1, 50, 2, 1, 4'b0000);
    press(0, 1, 0);  chk("min_up_wrap_no_carry", 4, 0, 1, 50, 2, 1, 4'b0000);
    ticks(50);       chk("blink_min", 4, 0, 1, 50, 2, 1, 4'b0011);
    press(1, 0, 0);  chk("exit_clears_sec_msec", 4, 0, 0, 0, 0, 0, 4'b0000);
    ticks(1);        chk("run_resumes", 4, 0, 0, 1, 0, 0, 4'b0000);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
